mdu_iter: RTL and testbench
===========================

// Module: mdu_iter
// PURPOSE
//  Parametrised multiply/divide unit with private HI/LO, successor to the inline mul/div+hilo in EX.
//  Multi-cycle multiplier (MUL_LAT stages) and 1-bit/cycle iterative divider replace vendor div IP cores.
//  Adds valid/ready request handshake, busy/done status, pipeline flush abort, div-by-zero definition.
//  Sits beside the ALU in exe_stage; EX stalls on !req_ready / busy exactly as it stalls on es_stop today.
// PARAMETERS
//  XLEN     32  operand width; HI/LO are XLEN each, product 2*XLEN
//  MUL_LAT  2   multiply latency in cycles, accept edge to HI/LO write (1..4)
//  CNT_W    6   iteration counter width, >= clog2(XLEN+1)
// PORTS
//  clk        in   1     clock, rising edge
//  resetn     in   1     asynchronous active-low reset
//  req_valid  in   1     request present (EX qualifies with es_valid)
//  req_ready  out  1     unit can accept; =1 only in IDLE
//  req_op     in   3     MDU_OP_*: MULT, MULTU, DIV, DIVU, MTHI, MTLO
//  req_src1   in   XLEN  multiplicand / dividend / MTHI-MTLO data
//  req_src2   in   XLEN  multiplier / divisor
//  flush      in   1     abort in-flight op (exception / ERET)
//  busy       out  1     op in flight (state != IDLE)
//  done       out  1     one-cycle pulse in the cycle after HI/LO update
//  hi_rdata   out  XLEN  current HI (registered, for MFHI)
//  lo_rdata   out  XLEN  current LO (registered, for MFLO)
// BEHAVIOUR
//  Reset: state=IDLE, HI=LO=0, cnt=0, done=0, busy=0, req_ready=1 (async assert, sync release).
//  Accept = req_valid & req_ready & !flush at a rising edge; operands latched there.
//  MTHI/MTLO: write HI/LO at the accept edge, no state change, no done pulse.
//  FSM IDLE->MUL on MULT/MULTU; MUL counts MUL_LAT-1 cycles, last edge writes {HI,LO}=product, ->IDLE.
//  FSM IDLE->DIV on DIV/DIVU; operands converted to magnitudes on accept (signed ops).
//  DIV: restoring, one quotient bit per cycle, XLEN cycles, cnt counts down XLEN-1..0; ->FIX at cnt==0.
//  FIX: one cycle; sign correction (quot neg iff signs differ, rem takes dividend sign);
//   edge writes LO=quotient, HI=remainder, ->IDLE. DIV/DIVU latency = XLEN+1 cycles accept->write.
//  done pulses in the cycle following any MUL/DIV HI/LO write.
//  Divide-by-zero: no trap; LO=all ones, HI=dividend (signed and unsigned), same latency.
//  Signed overflow 0x8000_0000 / -1: LO=0x8000_0000, HI=0 (falls out of magnitude path).
//  MULTU/DIVU: operands zero-extended; MULT/DIV: sign-extended to XLEN+1 internally.
//  flush: any non-IDLE state ->IDLE next edge, HI/LO unchanged, no done; flush wins over FIX/MUL final write.
//  flush with req_valid in IDLE: request dropped (MTHI/MTLO included).
//  hi_rdata/lo_rdata reflect HI/LO from the cycle after the write edge; no bypass of in-flight results.
//  req_op outside the six encodings: ignored, req_ready stays 1.
// STRUCTURE
//  Shared header mycpu.h: `define MDU_OP_W 3, MDU_OP_MULT..MDU_OP_MTLO encodings, MDU state codes.
//  One sub-module: mdu_div_core (iterative restoring divider, start/cnt/quot/rem, no HI/LO).
//  Multiplier inline: (XLEN+1)x(XLEN+1) signed product plus MUL_LAT-1 pipeline registers.
// TESTING
//  MULT -3 x 7 -> after 2 cycles HI=0xFFFF_FFFF, LO=0xFFFF_FFEB, done pulse once.
//  MULTU 0xFFFF_FFFF x 2 -> HI=0x0000_0001, LO=0xFFFF_FFFE.
//  DIV -7 / 2 -> 33 cycles, LO=0xFFFF_FFFD, HI=0xFFFF_FFFF; req_ready low throughout.
//  DIVU 100 / 0 -> LO=0xFFFF_FFFF, HI=100; DIV 0x8000_0000 / -1 -> LO=0x8000_0000, HI=0.
//  DIV started with HI=LO=5, flush at cycle 10 -> IDLE next edge, HI=LO=5, no done.
//  MTHI 0x1234 then MTLO 0x5678 back-to-back; resetn low mid-DIV -> HI=LO=0, req_ready=1 at once.

Source files
------------

// File: rtl/mdu_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit: opcode and FSM encodings.
package mdu_iter_pkg;

    localparam int unsigned MDU_OP_W = 3;

    typedef enum logic [MDU_OP_W-1:0] {
        MDU_OP_MULT  = 3'd0,
        MDU_OP_MULTU = 3'd1,
        MDU_OP_DIV   = 3'd2,
        MDU_OP_DIVU  = 3'd3,
        MDU_OP_MTHI  = 3'd4,
        MDU_OP_MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic [1:0] {
        MDU_IDLE,
        MDU_MUL,
        MDU_DIV,
        MDU_FIX
    } mdu_state_e;

    function automatic logic is_signed_op(input mdu_op_e op);
        return (op == MDU_OP_MULT) || (op == MDU_OP_DIV);
    endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// Request/status bundle between the EX stage and the multiply/divide unit.
interface mdu_iter_if #(
    parameter int unsigned XLEN = 32
);
    logic                                req_valid;
    logic                                req_ready;
    logic [mdu_iter_pkg::MDU_OP_W-1:0]   req_op;
    logic [XLEN-1:0]                     req_src1;
    logic [XLEN-1:0]                     req_src2;
    logic                                flush;
    logic                                busy;
    logic                                done;
    logic [XLEN-1:0]                     hi_rdata;
    logic [XLEN-1:0]                     lo_rdata;

    modport master (
        output req_valid, req_op, req_src1, req_src2, flush,
        input  req_ready, busy, done, hi_rdata, lo_rdata
    );

    modport slave (
        input  req_valid, req_op, req_src1, req_src2, flush,
        output req_ready, busy, done, hi_rdata, lo_rdata
    );
endinterface

// File: rtl/mdu_div_core.sv
// Unsigned restoring divider: one quotient bit per step, operands loaded on start.
module mdu_div_core #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quot,
    output logic [XLEN-1:0] rem
);
    logic [XLEN-1:0] dvs;
    logic [XLEN:0]   trial;

    // Partial remainder stays below the divisor, so bit XLEN of the trial is its sign.
    assign trial = {rem, quot[XLEN-1]} - {1'b0, dvs};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            quot <= '0;
            rem  <= '0;
            dvs  <= '0;
        end else if (start) begin
            quot <= dividend;
            rem  <= '0;
            dvs  <= divisor;
        end else if (step) begin
            if (!trial[XLEN]) begin
                rem  <= trial[XLEN-1:0];
                quot <= {quot[XLEN-2:0], 1'b1};
            end else begin
                rem  <= {rem[XLEN-2:0], quot[XLEN-1]};
                quot <= {quot[XLEN-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// Multiply/divide unit with private HI/LO: pipelined multiplier, iterative divider, flush abort.
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned CNT_W   = 6
) (
    input  logic      clk,
    input  logic      resetn,
    mdu_iter_if.slave bus
);
    mdu_state_e          state, state_next;
    mdu_op_e             op;
    logic                accept, is_signed;
    logic [CNT_W-1:0]    cnt;
    logic [XLEN-1:0]     hi, lo;
    logic                done_r;
    logic                mt_hi, mt_lo, mul_start, div_start, div_step, mul_wr, div_wr;
    logic [XLEN:0]       mul_a, mul_b;
    logic [2*XLEN-1:0]   mul_a_ext, mul_b_ext, prod, mul_res;
    logic [XLEN-1:0]     src1_mag, src2_mag, quot, rem, quot_fix, rem_fix;
    logic                quot_neg, rem_neg, div_zero;

    assign op        = mdu_op_e'(bus.req_op);
    assign accept    = bus.req_valid && bus.req_ready && !bus.flush;
    assign is_signed = is_signed_op(op);

    assign bus.req_ready = (state == MDU_IDLE);
    assign bus.busy      = (state != MDU_IDLE);
    assign bus.done      = done_r;
    assign bus.hi_rdata  = hi;
    assign bus.lo_rdata  = lo;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= MDU_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        mt_hi      = 1'b0;
        mt_lo      = 1'b0;
        mul_start  = 1'b0;
        div_start  = 1'b0;
        div_step   = 1'b0;
        mul_wr     = 1'b0;
        div_wr     = 1'b0;
        case (state)
            MDU_IDLE: begin
                if (accept) begin
                    case (op)
                        MDU_OP_MULT, MDU_OP_MULTU: begin
                            mul_start  = 1'b1;
                            state_next = MDU_MUL;
                        end
                        MDU_OP_DIV, MDU_OP_DIVU: begin
                            div_start  = 1'b1;
                            state_next = MDU_DIV;
                        end
                        MDU_OP_MTHI: mt_hi = 1'b1;
                        MDU_OP_MTLO: mt_lo = 1'b1;
                        default: ;
                    endcase
                end
            end
            MDU_MUL: begin
                if (bus.flush) begin
                    state_next = MDU_IDLE;
                end else if (cnt == '0) begin
                    mul_wr     = 1'b1;
                    state_next = MDU_IDLE;
                end
            end
            MDU_DIV: begin
                if (bus.flush) begin
                    state_next = MDU_IDLE;
                end else begin
                    div_step = 1'b1;
                    if (cnt == '0) state_next = MDU_FIX;
                end
            end
            MDU_FIX: begin
                if (!bus.flush) div_wr = 1'b1;
                state_next = MDU_IDLE;
            end
            default: state_next = MDU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                                           cnt <= '0;
        else if (bus.flush)                                    cnt <= '0;
        else if (mul_start)                                    cnt <= CNT_W'(MUL_LAT - 1);
        else if (div_start)                                    cnt <= CNT_W'(XLEN - 1);
        else if ((state == MDU_MUL || state == MDU_DIV) && cnt != '0) cnt <= cnt - CNT_W'(1);
    end

    // Operands carried as XLEN+1 bits so MULT and MULTU share one signed multiplier.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mul_a <= '0;
            mul_b <= '0;
        end else if (mul_start) begin
            mul_a <= {is_signed & bus.req_src1[XLEN-1], bus.req_src1};
            mul_b <= {is_signed & bus.req_src2[XLEN-1], bus.req_src2};
        end
    end

    assign mul_a_ext = {{(XLEN-1){mul_a[XLEN]}}, mul_a};
    assign mul_b_ext = {{(XLEN-1){mul_b[XLEN]}}, mul_b};
    assign prod      = mul_a_ext * mul_b_ext;

    generate
        if (MUL_LAT > 1) begin : g_mul_pipe
            logic [2*XLEN-1:0] pipe [MUL_LAT-1];
            always_ff @(posedge clk) begin
                pipe[0] <= prod;
                for (int unsigned i = 1; i < MUL_LAT - 1; i++) pipe[i] <= pipe[i-1];
            end
            assign mul_res = pipe[MUL_LAT-2];
        end else begin : g_mul_comb
            assign mul_res = prod;
        end
    endgenerate

    assign src1_mag = (is_signed && bus.req_src1[XLEN-1]) ? -bus.req_src1 : bus.req_src1;
    assign src2_mag = (is_signed && bus.req_src2[XLEN-1]) ? -bus.req_src2 : bus.req_src2;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            quot_neg <= 1'b0;
            rem_neg  <= 1'b0;
            div_zero <= 1'b0;
        end else if (div_start) begin
            quot_neg <= is_signed & (bus.req_src1[XLEN-1] ^ bus.req_src2[XLEN-1]);
            rem_neg  <= is_signed & bus.req_src1[XLEN-1];
            div_zero <= (bus.req_src2 == '0);
        end
    end

    mdu_div_core #(.XLEN(XLEN)) u_div (
        .clk      (clk),
        .resetn   (resetn),
        .start    (div_start),
        .step     (div_step),
        .dividend (src1_mag),
        .divisor  (src2_mag),
        .quot     (quot),
        .rem      (rem)
    );

    // Zero divisor leaves the dividend magnitude in rem, so only the quotient needs forcing.
    assign quot_fix = div_zero ? '1 : (quot_neg ? -quot : quot);
    assign rem_fix  = rem_neg ? -rem : rem;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi     <= '0;
            lo     <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= mul_wr | div_wr;
            if (mt_hi) hi <= bus.req_src1;
            if (mt_lo) lo <= bus.req_src1;
            if (mul_wr) {hi, lo} <= mul_res;
            if (div_wr) begin
                hi <= rem_fix;
                lo <= quot_fix;
            end
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Randomized self-checking bench for mdu_iter against an arithmetic HI/LO reference model.
module tb_mdu_iter;
    import mdu_iter_pkg::*;

    localparam int MUL_LATENCY = 2;
    localparam int DIV_LATENCY = 33;

    logic clk;
    logic resetn;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [31:0] mhi = '0;
    logic [31:0] mlo = '0;

    mdu_iter_if #(.XLEN(32)) bus ();

    mdu_iter #(.XLEN(32), .MUL_LAT(2), .CNT_W(6)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        int     sa, sb;
        longint sp;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            MDU_OP_MULT: begin
                sp = longint'(sa) * longint'(sb);
                return sp;
            end
            MDU_OP_MULTU: return {32'd0, a} * {32'd0, b};
            MDU_OP_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            MDU_OP_DIVU: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return '0;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20)) - 32'd10;
            default: return $urandom;
        endcase
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_src1  = a;
        bus.req_src2  = b;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        logic [63:0] exp_hilo;
        int          cyc;
        bit          status_bad;
        int          lat;
        if (op == MDU_OP_MTHI || op == MDU_OP_MTLO) begin
            issue(op, a, b);
            if (op == MDU_OP_MTHI) mhi = a;
            else                   mlo = a;
            check({tag, " hi"}, bus.hi_rdata, mhi);
            check({tag, " lo"}, bus.lo_rdata, mlo);
            check({tag, " no done"}, bus.done, 0);
            check({tag, " ready"}, bus.req_ready, 1);
            return;
        end
        exp_hilo = ref_result(op, a, b);
        lat = (op == MDU_OP_MULT || op == MDU_OP_MULTU) ? MUL_LATENCY : DIV_LATENCY;
        issue(op, a, b);
        cyc = 0;
        status_bad = 1'b0;
        while (bus.done !== 1'b1 && cyc < 100) begin
            if (bus.req_ready !== 1'b0 || bus.busy !== 1'b1) status_bad = 1'b1;
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, " latency"}, cyc, lat);
        check({tag, " busy/ready in flight"}, status_bad, 0);
        check({tag, " hi"}, bus.hi_rdata, exp_hilo[63:32]);
        check({tag, " lo"}, bus.lo_rdata, exp_hilo[31:0]);
        mhi = exp_hilo[63:32];
        mlo = exp_hilo[31:0];
        @(posedge clk);
        #1;
        check({tag, " done one cycle"}, bus.done, 0);
        check({tag, " ready after"}, bus.req_ready, 1);
    endtask

    task automatic run_flush(input string tag, input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] b, input int k);
        bit done_seen;
        issue(op, a, b);
        repeat (k - 1) @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check({tag, " busy"}, bus.busy, 0);
        check({tag, " ready"}, bus.req_ready, 1);
        done_seen = 1'b0;
        repeat (40) begin
            if (bus.done === 1'b1) done_seen = 1'b1;
            @(posedge clk);
            #1;
        end
        check({tag, " no done"}, done_seen, 0);
        check({tag, " hi kept"}, bus.hi_rdata, mhi);
        check({tag, " lo kept"}, bus.lo_rdata, mlo);
    endtask

    initial begin
        resetn        = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_src1  = '0;
        bus.req_src2  = '0;
        bus.flush     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset ready", bus.req_ready, 1);
        check("reset busy", bus.busy, 0);
        check("reset done", bus.done, 0);
        check("reset hi", bus.hi_rdata, 0);
        check("reset lo", bus.lo_rdata, 0);
        @(negedge clk);
        resetn = 1'b1;

        run_op("mult -3x7", MDU_OP_MULT, 32'hFFFF_FFFD, 32'd7);
        check("mult -3x7 const hi", bus.hi_rdata, 32'hFFFF_FFFF);
        check("mult -3x7 const lo", bus.lo_rdata, 32'hFFFF_FFEB);
        run_op("multu max x2", MDU_OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        check("multu const hi", bus.hi_rdata, 32'h0000_0001);
        run_op("div -7/2", MDU_OP_DIV, 32'hFFFF_FFF9, 32'd2);
        check("div -7/2 const lo", bus.lo_rdata, 32'hFFFF_FFFD);
        run_op("divu 100/0", MDU_OP_DIVU, 32'd100, 32'd0);
        run_op("div -7/0", MDU_OP_DIV, 32'hFFFF_FFF9, 32'd0);
        run_op("div ovf", MDU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div ovf const lo", bus.lo_rdata, 32'h8000_0000);

        // MTHI then MTLO on consecutive edges
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = MDU_OP_MTHI;
        bus.req_src1  = 32'h1234;
        @(posedge clk);
        #1;
        check("mthi b2b hi", bus.hi_rdata, 32'h1234);
        bus.req_op   = MDU_OP_MTLO;
        bus.req_src1 = 32'h5678;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        mhi = 32'h1234;
        mlo = 32'h5678;
        check("mtlo b2b lo", bus.lo_rdata, 32'h5678);
        check("mtlo b2b hi", bus.hi_rdata, 32'h1234);
        check("mt b2b no done", bus.done, 0);

        for (int op = 6; op < 8; op++) begin
            issue(3'(op), 32'hDEAD_BEEF, 32'd3);
            check("bad op ready", bus.req_ready, 1);
            check("bad op busy", bus.busy, 0);
            check("bad op hi", bus.hi_rdata, mhi);
            check("bad op lo", bus.lo_rdata, mlo);
        end

        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = MDU_OP_MTHI;
        bus.req_src1  = 32'hABCD;
        bus.flush     = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
        check("idle flush drops mthi", bus.hi_rdata, mhi);

        run_op("mthi 5", MDU_OP_MTHI, 32'd5, 32'd0);
        run_op("mtlo 5", MDU_OP_MTLO, 32'd5, 32'd0);
        run_flush("flush div c10", MDU_OP_DIV, 32'd100, 32'd3, 10);
        check("flush div hi=5", bus.hi_rdata, 32'd5);
        run_flush("flush mul last", MDU_OP_MULT, 32'd9, 32'd9, MUL_LATENCY);
        run_flush("flush fix", MDU_OP_DIVU, 32'd77, 32'd5, DIV_LATENCY);
        run_flush("flush div early", MDU_OP_DIV, 32'd50, 32'd7, 1);

        for (int n = 0; n < 40; n++) begin
            logic [2:0] rop;
            rop = 3'($urandom_range(0, 5));
            run_op($sformatf("rand%0d op%0d", n, rop), rop, pick(), pick());
        end

        run_op("pre-reset mthi", MDU_OP_MTHI, 32'hCAFE, 32'd0);
        issue(MDU_OP_DIV, 32'd1000, 32'd7);
        repeat (5) @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        check("async reset hi", bus.hi_rdata, 0);
        check("async reset lo", bus.lo_rdata, 0);
        check("async reset ready", bus.req_ready, 1);
        check("async reset busy", bus.busy, 0);
        mhi = '0;
        mlo = '0;
        @(negedge clk);
        resetn = 1'b1;
        run_op("post-reset mult", MDU_OP_MULT, 32'h7FFF_FFFF, 32'h8000_0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
